// File: rtl/apb_slave_mem.sv
// Word-addressed APB3 completer backed by resettable register storage.
// Supports 0-15 programmable wait states, error responses and transfer abort.
module apb_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [3:0]            wait_cycles,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic [7:0]            err_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic             setup;
  logic [IDX_W-1:0] paddr_idx;
  logic             paddr_err;
  logic             rsp_ld;
  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_err;
  logic             rsp_write;

  assign setup     = PSEL && !PENABLE;
  assign paddr_idx = PADDR[IDX_W+1:2];
  assign paddr_err = (PADDR[1:0] != 2'b00) || (PADDR[ADDR_WIDTH-1:IDX_W+2] != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    write_d     = write_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    err_count_d = err_count_q;
    mem_d       = mem_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    rsp_ld      = 1'b0;
    rsp_idx     = idx_q;
    rsp_err     = err_q;
    rsp_write   = write_q;

    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          idx_d   = paddr_idx;
          write_d = PWRITE;
          err_d   = paddr_err;
          wdata_d = PWDATA;
          cnt_d   = wait_cycles;
          // Zero-wait transfers must present the response in the very next cycle.
          if (wait_cycles == 4'd0) begin
            rsp_ld    = 1'b1;
            rsp_idx   = paddr_idx;
            rsp_err   = paddr_err;
            rsp_write = PWRITE;
          end
        end
      end
      ACCESS: begin
        if (pready_q) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (err_q) begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end else if (write_q) begin
            mem_d[idx_q] = wdata_q;
          end
        end else if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) rsp_ld = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rsp_ld) begin
      pready_d  = 1'b1;
      pslverr_d = rsp_err;
      prdata_d  = (rsp_err || rsp_write) ? '0 : mem_q[rsp_idx];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      err_count_q <= 8'd0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      err_count_q <= err_count_d;
      mem_q       <= mem_d;
    end
  end

  assign PREADY    = pready_q;
  assign PRDATA    = prdata_q;
  assign PSLVERR   = pslverr_q;
  assign err_count = err_count_q;

endmodule
